serial_ripple_subtractor: RTL and testbench

SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

---
 rtl/serial_ripple_subtractor.sv | 110 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial unsigned subtractor: computes (A - B - BIN) mod 2^WIDTH one bit
// per clock, LSB first, with a borrow-out. A request is accepted from IDLE or
// from the one-cycle FIN state, so back-to-back results arrive every WIDTH+1
// cycles.
//
// Handshake: START is a request sampled on a rising edge while BUSY is low
// (IDLE or FIN); it is ignored while BUSY is high. DONE is a one-cycle pulse
// whose cycle carries a valid DIFF/BOUT; DIFF/BOUT then hold until the next
// completion or reset.
module serial_ripple_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  assign dbg_state = state;

  // One full-subtractor cell plus the next value of the result shifter.
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ br;
    br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next = {d, res_sr[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM with datapath shifters; BUSY/DONE registered alongside state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DIFF   <= '0;
      BOUT   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= BIN;
            res_sr <= '0;
            cnt    <= '0;
            state  <= RUN;
            BUSY   <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next;
          res_sr <= res_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            // Result outputs are only written here, so they hold otherwise.
            DIFF  <= res_next;
            BOUT  <= br_next;
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor at WIDTH=3. Expected
// results are pushed when a request is driven and popped by a monitor on
// each DONE pulse.
module tb_serial_ripple_subtractor;

  localparam int W = 3;

  logic         CLK;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BIN;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] DIFF;
  logic         BOUT;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  int           n_checks;
  int           n_pass;
  int           done_cnt;
  int           cyc;
  logic [W-1:0] hold_diff;
  logic         hold_bout;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .A         (A),
    .B         (B),
    .BIN       (BIN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DIFF      (DIFF),
    .BOUT      (BOUT),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference: signed integer subtraction, then wrap and sign for borrow.
  function automatic logic [W:0] model(input int a, input int b, input int bin);
    int           t;
    logic [W-1:0] dd;
    t  = a - b - bin;
    dd = t[W-1:0];
    return {(t < 0), dd};
  endfunction

  // Result-hold model follows reset.
  always @(posedge CLK) begin
    if (RST) begin
      hold_diff = '0;
      hold_bout = 1'b0;
    end
  end

  // Scoreboard: every DONE pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    logic [W:0] e;
    if (DONE) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", DIFF, e[W-1:0]);
        check("bout", BOUT, e[W]);
        hold_diff = e[W-1:0];
        hold_bout = e[W];
      end
    end
  end

  // Driver: one request from idle, checking BUSY/DONE timing cycle by cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge CLK);
    A = a; B = b; BIN = bin; START = 1'b1;
    exp_q.push_back(model(a, b, bin));
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom_range(0, 7)); B = W'($urandom_range(0, 7)); BIN = 1'($urandom_range(0, 1));
    check("busy_e0", BUSY, 1);
    check("done_e0", DONE, 0);
    for (int i = 1; i < W; i++) begin
      @(negedge CLK);
      check("busy_run", BUSY, 1);
      check("done_run", DONE, 0);
      check("diff_hold", DIFF, hold_diff);
      check("bout_hold", BOUT, hold_bout);
    end
    @(negedge CLK);
    check("busy_fin", BUSY, 0);
    check("done_fin", DONE, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!DONE && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!DONE) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    int t1;
    n_checks = 0; n_pass = 0; done_cnt = 0; cyc = 0;
    hold_diff = '0; hold_bout = 1'b0;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; BIN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_diff", DIFF, 0);
    check("rst_bout", BOUT, 0);
    @(negedge CLK);
    check("idle_busy", BUSY, 0);

    // Basic and wrap/borrow vectors
    run_op(3'd7, 3'd3, 1'b0);
    run_op(3'd3, 3'd7, 1'b0);
    run_op(3'd0, 3'd0, 1'b1);
    run_op(3'd2, 3'd1, 1'b0);

    // START while busy is ignored
    @(negedge CLK);
    A = 3'd5; B = 3'd2; BIN = 1'b0; START = 1'b1;
    exp_q.push_back(model(5, 2, 0));
    @(negedge CLK);
    A = 3'd0; B = 3'd7; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    base = done_cnt;
    check("busy_start_busy", BUSY, 1);
    wait_done("busy_start_timeout");
    repeat (6) begin
      @(negedge CLK);
      check("busy_start_idle", BUSY, 0);
    end
    check("busy_start_single", done_cnt - base, 1);

    // Back-to-back with START held through FIN
    @(negedge CLK);
    A = 3'd6; B = 3'd1; BIN = 1'b0; START = 1'b1;
    exp_q.push_back(model(6, 1, 0));
    @(negedge CLK);
    wait_done("b2b_first_timeout");
    A = 3'd1; B = 3'd2;
    exp_q.push_back(model(1, 2, 0));
    t1 = cyc;
    @(negedge CLK);
    START = 1'b0;
    check("b2b_restart_busy", BUSY, 1);
    wait_done("b2b_second_timeout");
    check("b2b_gap", cyc - t1, 4);
    @(negedge CLK);
    check("b2b_after_done", DONE, 0);
    check("b2b_after_busy", BUSY, 0);

    // Reset in the middle of an operation
    @(negedge CLK);
    A = 3'd7; B = 3'd3; BIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_diff", DIFF, 0);
    check("abort_bout", BOUT, 0);
    base = done_cnt;
    repeat (5) @(negedge CLK);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_idle_busy", BUSY, 0);
    run_op(3'd4, 3'd4, 1'b0);

    // Reset and START together start nothing
    @(negedge CLK);
    RST = 1'b1; START = 1'b1; A = 3'd5; B = 3'd1;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    check("rst_start_busy", BUSY, 0);
    check("rst_start_diff", DIFF, 0);
    base = done_cnt;
    repeat (5) @(negedge CLK);
    check("rst_start_no_done", done_cnt - base, 0);
    check("rst_start_idle", BUSY, 0);

    // Exhaustive sweep
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          run_op(W'(a), W'(b), 1'(c));

    repeat (3) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
